multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the 4-register, 8-word single-cycle controller. It runs a program from an internal instruction memory through an explicit FETCH/DECODE/EXEC/MEM/WB state machine. It drives an internal ALU and owns the register file and data memory. The instruction memory is loaded through a write port while the block is idle. Instrumentation outputs expose the register file, ALU operands and status to the top level and testbench.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with internal instruction memory,
// data memory, register file and ALU. Define CTRL_BRANCH_EN to add the BEQ instruction (op 0x02).
module multicycle_control #(
   parameter int DW         = 32,
   parameter int NREG       = 4,
   parameter int RAW        = 2,
   parameter int IMEM_DEPTH = 8,
   parameter int IAW        = 3,
   parameter int DMEM_DEPTH = 8,
   parameter int DAW        = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [NREG*DW-1:0] reg_init,
   input  logic               im_we,
   input  logic [IAW-1:0]     im_waddr,
   input  logic [DW-1:0]      im_wdata,
   output logic [NREG*DW-1:0] reg_flat,
   output logic [DW-1:0]      alu_a,
   output logic [DW-1:0]      alu_b,
   output logic [DW-1:0]      alu_out,
   output logic [IAW:0]       pc,
   output logic               busy,
   output logic               done,
   output logic               addr_err
);

   localparam logic [7:0] OP_ADD   = 8'h20;
   localparam logic [7:0] OP_SUB   = 8'h10;
   localparam logic [7:0] OP_SLA   = 8'h08;
   localparam logic [7:0] OP_SRA   = 8'h04;
   localparam logic [7:0] OP_STORE = 8'h40;
   localparam logic [7:0] OP_LOAD  = 8'h80;
   localparam logic [7:0] OP_HALT  = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [DW-1:0] ir, mdr;
   logic [DW-1:0] rf   [NREG];
   logic [DW-1:0] dmem [DMEM_DEPTH];
   logic [DW-1:0] imem [IMEM_DEPTH];

   logic [7:0]     op;
   logic [RAW-1:0] rs, rt, rd;
   logic [IAW:0]   pc_inc;
   logic           last, mem_ok, is_alu, is_mem;

   assign op     = ir[31:24];
   assign rs     = ir[16 +: RAW];
   assign rt     = ir[8 +: RAW];
   assign rd     = ir[0 +: RAW];
   assign pc_inc = pc + (IAW+1)'(1);
   assign last   = (pc_inc == (IAW+1)'(IMEM_DEPTH));
   assign mem_ok = (alu_out < DW'(DMEM_DEPTH));
   assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLA) || (op == OP_SRA);
   assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

`ifdef CTRL_BRANCH_EN
   localparam logic [7:0] OP_BEQ = 8'h02;
   logic             is_beq, br_take, br_ok;
   logic [IAW+9:0]   br_tgt;
   assign is_beq  = (op == OP_BEQ);
   assign br_take = (alu_a == alu_b);
   // Wide enough that a negative target shows up as a set MSB.
   assign br_tgt  = {9'b0, pc_inc} + {{(IAW+2){ir[7]}}, ir[7:0]};
   assign br_ok   = !br_tgt[IAW+9] && (br_tgt < (IAW+10)'(IMEM_DEPTH));
`else
   logic unused_bits;
   assign unused_bits = ^ir[7:RAW];
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            if (op == OP_HALT)           state_nxt = S_DONE;
            else if (is_alu || is_mem)   state_nxt = S_EXEC;
`ifdef CTRL_BRANCH_EN
            else if (is_beq)             state_nxt = S_EXEC;
`endif
            else                         state_nxt = last ? S_DONE : S_FETCH;
         end
         S_EXEC: begin
            if (is_mem)       state_nxt = S_MEM;
`ifdef CTRL_BRANCH_EN
            else if (is_beq)  state_nxt = br_take ? (br_ok ? S_FETCH : S_DONE)
                                                  : (last ? S_DONE : S_FETCH);
`endif
            else              state_nxt = S_WB;
         end
         S_MEM:    state_nxt = (op == OP_LOAD) ? S_WB : (last ? S_DONE : S_FETCH);
         S_WB:     state_nxt = last ? S_DONE : S_FETCH;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);

   always_comb begin
      alu_out = alu_a + alu_b;
      case (op)
         OP_SUB: alu_out = alu_a - alu_b;
         OP_SLA: alu_out = (alu_b >= DW'(DW)) ? '0 : (alu_a << alu_b);
         OP_SRA: alu_out = (alu_b >= DW'(DW)) ? {DW{alu_a[DW-1]}}
                                              : DW'($signed(alu_a) >>> alu_b);
         default: ;
      endcase
   end

   always_comb begin
      reg_flat = '0;
      for (int unsigned i = 0; i < NREG; i++) reg_flat[i*DW +: DW] = rf[i];
   end

   always_ff @(posedge CLK) begin
      if (im_we && state == S_IDLE) imem[im_waddr] <= im_wdata;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         pc       <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         ir       <= '0;
         mdr      <= '0;
         addr_err <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
         for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i] <= DW'(i);
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (start) begin
               pc       <= '0;
               addr_err <= 1'b0;
               for (int unsigned i = 0; i < NREG; i++) rf[i] <= reg_init[i*DW +: DW];
            end
            S_FETCH: ir <= imem[pc[IAW-1:0]];
            S_DECODE: begin
               if (op == OP_ADD || op == OP_SUB) begin
                  alu_a <= rf[rs];
                  alu_b <= rf[rt];
               end else if (op == OP_SLA || op == OP_SRA) begin
                  alu_a <= rf[rs];
                  alu_b <= {{(DW-8){1'b0}}, ir[15:8]};
               end else if (is_mem) begin
                  alu_a <= {{(DW-8){1'b0}}, ir[23:16]};
                  alu_b <= '0;
`ifdef CTRL_BRANCH_EN
               end else if (is_beq) begin
                  alu_a <= rf[rs];
                  alu_b <= rf[rt];
`endif
               end else if (op != OP_HALT) begin
                  pc <= pc_inc;
               end
            end
`ifdef CTRL_BRANCH_EN
            S_EXEC: if (is_beq) begin
               // An out-of-range taken target ends the run with pc left at the branch.
               if (!br_take)   pc <= pc_inc;
               else if (br_ok) pc <= br_tgt[IAW:0];
            end
`endif
            S_MEM: begin
               if (!mem_ok) addr_err <= 1'b1;
               if (op == OP_LOAD) begin
                  mdr <= mem_ok ? dmem[alu_out[DAW-1:0]] : '0;
               end else begin
                  if (mem_ok) dmem[alu_out[DAW-1:0]] <= rf[rt];
                  pc <= pc_inc;
               end
            end
            S_WB: begin
               if (op == OP_LOAD) rf[rt] <= mdr;
               else               rf[rd] <= alu_out;
               pc <= pc_inc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; branch scenarios run only when
// CTRL_BRANCH_EN is defined.
module tb_multicycle_control;

   localparam int DW = 32, NREG = 4, RAW = 2, IMEM_DEPTH = 8, IAW = 3, DMEM_DEPTH = 8, DAW = 3;
   localparam logic [DW-1:0] HALT = 32'h01000000;
   localparam logic [DW-1:0] ADD_R0_R1_R2 = 32'h20010200;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               start = 1'b0;
   logic [NREG*DW-1:0] reg_init = '0;
   logic               im_we = 1'b0;
   logic [IAW-1:0]     im_waddr = '0;
   logic [DW-1:0]      im_wdata = '0;
   logic [NREG*DW-1:0] reg_flat;
   logic [DW-1:0]      alu_a, alu_b, alu_out;
   logic [IAW:0]       pc;
   logic               busy, done, addr_err;

   int checks = 0;
   int errors = 0;

   multicycle_control #(
      .DW(DW), .NREG(NREG), .RAW(RAW), .IMEM_DEPTH(IMEM_DEPTH),
      .IAW(IAW), .DMEM_DEPTH(DMEM_DEPTH), .DAW(DAW)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .reg_init(reg_init),
      .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
      .reg_flat(reg_flat), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
      .pc(pc), .busy(busy), .done(done), .addr_err(addr_err)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] rget(input int i);
      return reg_flat[i*DW +: DW];
   endfunction

   task automatic write_imem(input logic [IAW-1:0] a, input logic [DW-1:0] d);
      im_we = 1'b1; im_waddr = a; im_wdata = d;
      @(negedge CLK);
      im_we = 1'b0;
   endtask

   task automatic kick(input logic [NREG*DW-1:0] init);
      reg_init = init; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; im_we = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output bit timed_out);
      cycles = 0;
      while (done !== 1'b1 && cycles < 300) begin
         @(negedge CLK);
         cycles++;
      end
      timed_out = (done !== 1'b1);
   endtask

   task automatic apply_reset();
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #2 RST = 1'b0;
      #2;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || addr_err !== 1'b0) begin errors++;
         $display("FAIL reset_flags got busy=%b done=%b err=%b exp 0 0 0", busy, done, addr_err); end
      checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
      checks++; if (reg_flat !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", reg_flat); end
      checks++; if (alu_a !== '0 || alu_b !== '0 || alu_out !== '0) begin errors++;
         $display("FAIL reset_alu got a=%h b=%h out=%h exp 0", alu_a, alu_b, alu_out); end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_add_halt();
      int cyc; bit to;
      write_imem(0, ADD_R0_R1_R2);
      write_imem(1, HALT);
      kick({32'd4, 32'd3, 32'd2, 32'd1});
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_start got %b exp 1", busy); end
      wait_done(cyc, to);
      checks++; if (to) begin errors++; $display("FAIL add_timeout got no done exp done"); end
      checks++; if (cyc != 6) begin errors++; $display("FAIL add_latency got %0d exp 6", cyc); end
      checks++; if (rget(0) !== 32'd5) begin errors++; $display("FAIL add_r0 got %h exp 5", rget(0)); end
      checks++; if (pc !== 4'd1) begin errors++; $display("FAIL add_pc got %0d exp 1", pc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_done got %b exp 0", busy); end
      @(negedge CLK);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL add_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
   endtask

   task automatic test_alu_ops();
      int cyc; bit to;
      write_imem(0, 32'h04010402);   // SRA r2 = r1 >>> 4
      write_imem(1, 32'h08012803);   // SLA r3 = r1 << 40
      write_imem(2, 32'h04012800);   // SRA r0 = r1 >>> 40
      write_imem(3, HALT);
      kick({32'h12345678, 32'h0, 32'h80000000, 32'h0});
      wait_done(cyc, to);
      checks++; if (to || cyc != 14) begin errors++; $display("FAIL shift_latency got %0d to=%b exp 14", cyc, to); end
      checks++; if (rget(2) !== 32'hF8000000) begin errors++; $display("FAIL sra4 got %h exp f8000000", rget(2)); end
      checks++; if (rget(3) !== 32'h0) begin errors++; $display("FAIL sla40 got %h exp 0", rget(3)); end
      checks++; if (rget(0) !== 32'hFFFFFFFF) begin errors++; $display("FAIL sra40 got %h exp ffffffff", rget(0)); end
      checks++; if (alu_a !== 32'h80000000 || alu_b !== 32'd40) begin errors++;
         $display("FAIL shift_operands got a=%h b=%h exp 80000000 28", alu_a, alu_b); end
      @(negedge CLK);
      write_imem(0, 32'h10000102);   // SUB r2 = r0 - r1
      write_imem(1, 32'h20030003);   // ADD r3 = r3 + r0
      write_imem(2, HALT);
      kick({32'hFFFFFFFF, 32'h0, 32'd2, 32'd1});
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (alu_a !== 32'd1 || alu_b !== 32'd2 || alu_out !== 32'hFFFFFFFF) begin errors++;
         $display("FAIL sub_exec got a=%h b=%h out=%h exp 1 2 ffffffff", alu_a, alu_b, alu_out); end
      wait_done(cyc, to);
      checks++; if (to || cyc != 8) begin errors++; $display("FAIL sub_latency got %0d to=%b exp 8", cyc, to); end
      checks++; if (rget(2) !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub got %h exp ffffffff", rget(2)); end
      checks++; if (rget(3) !== 32'h0) begin errors++; $display("FAIL add_wrap got %h exp 0", rget(3)); end
      @(negedge CLK);
   endtask

   task automatic test_store_load();
      int cyc; bit to;
      write_imem(0, 32'h40050300);   // STORE D[5] = r3
      write_imem(1, 32'h80050000);   // LOAD r0 = D[5]
      write_imem(2, HALT);
      kick({32'hAB, 32'h0, 32'h0, 32'h0});
      wait_done(cyc, to);
      checks++; if (to || cyc != 11) begin errors++; $display("FAIL stld_latency got %0d to=%b exp 11", cyc, to); end
      checks++; if (rget(0) !== 32'hAB) begin errors++; $display("FAIL stld_r0 got %h exp ab", rget(0)); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL stld_err got %b exp 0", addr_err); end
      @(negedge CLK);
      apply_reset();
      write_imem(0, 32'h80060100);   // LOAD r1 = D[6]
      write_imem(1, HALT);
      kick('0);
      wait_done(cyc, to);
      checks++; if (to || cyc != 7) begin errors++; $display("FAIL ld6_latency got %0d to=%b exp 7", cyc, to); end
      checks++; if (rget(1) !== 32'd6) begin errors++; $display("FAIL ld6_r1 got %h exp 6", rget(1)); end
      @(negedge CLK);
   endtask

   task automatic test_addr_err();
      int cyc; bit to;
      write_imem(0, 32'h80090200);   // LOAD r2 = D[9] (out of range)
      write_imem(1, 32'h40090300);   // STORE D[9] = r3 (dropped)
      write_imem(2, 32'h80010000);   // LOAD r0 = D[1]
      write_imem(3, HALT);
      kick({32'h99, 32'h55, 32'h0, 32'h0});
      wait_done(cyc, to);
      checks++; if (to || cyc != 16) begin errors++; $display("FAIL err_latency got %0d to=%b exp 16", cyc, to); end
      checks++; if (rget(2) !== 32'h0) begin errors++; $display("FAIL err_load got %h exp 0", rget(2)); end
      checks++; if (rget(0) !== 32'd1) begin errors++; $display("FAIL err_store_drop got %h exp 1", rget(0)); end
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", addr_err); end
      @(negedge CLK);
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", addr_err); end
      write_imem(0, HALT);
      kick('0);
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", addr_err); end
      wait_done(cyc, to);
      checks++; if (to || cyc != 2) begin errors++; $display("FAIL halt_latency got %0d to=%b exp 2", cyc, to); end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit to;
      write_imem(0, 32'h03000000);   // NOP
      write_imem(1, 32'h40020100);   // STORE D[2] = r1
      write_imem(2, HALT);
      kick({32'h0, 32'h0, 32'hDEAD, 32'h0});
      repeat (5) @(negedge CLK);     // now in MEM of the STORE
      RST = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || addr_err !== 1'b0) begin errors++;
         $display("FAIL midrst_flags got busy=%b done=%b err=%b exp 0 0 0", busy, done, addr_err); end
      checks++; if (pc !== '0 || reg_flat !== '0) begin errors++;
         $display("FAIL midrst_state got pc=%0d regs=%h exp 0 0", pc, reg_flat); end
      checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++;
         $display("FAIL midrst_alu got a=%h b=%h exp 0 0", alu_a, alu_b); end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      write_imem(0, 32'h80020000);   // LOAD r0 = D[2]
      write_imem(1, HALT);
      kick('0);
      wait_done(cyc, to);
      checks++; if (to || rget(0) !== 32'd2) begin errors++; $display("FAIL midrst_mem got %h to=%b exp 2", rget(0), to); end
      @(negedge CLK);
   endtask

   task automatic test_busy_ignores();
      int cyc; bit to;
      write_imem(0, ADD_R0_R1_R2);
      write_imem(1, HALT);
      kick({32'd4, 32'd3, 32'd2, 32'd1});
      start = 1'b1; im_we = 1'b1; im_waddr = 3'd1; im_wdata = 32'h03000000;
      @(negedge CLK);
      start = 1'b0; im_we = 1'b0;
      wait_done(cyc, to);
      checks++; if (to || cyc != 5) begin errors++; $display("FAIL busy_ignore_latency got %0d to=%b exp 5", cyc, to); end
      checks++; if (pc !== 4'd1 || rget(0) !== 32'd5) begin errors++;
         $display("FAIL busy_ignore_result got pc=%0d r0=%h exp 1 5", pc, rget(0)); end
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL busy_ignore_idle got busy=%b done=%b exp 0 0", busy, done); end
   endtask

   task automatic test_write_with_start();
      int cyc; bit to;
      write_imem(0, HALT);
      write_imem(1, HALT);
      im_we = 1'b1; im_waddr = 3'd0; im_wdata = ADD_R0_R1_R2;
      kick({32'd4, 32'd3, 32'd2, 32'd1});
      wait_done(cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL we_start_latency got %0d to=%b exp 6", cyc, to); end
      checks++; if (rget(0) !== 32'd5) begin errors++; $display("FAIL we_start_r0 got %h exp 5", rget(0)); end
      @(negedge CLK);
   endtask

   task automatic test_run_off_end();
      int cyc; bit to;
      logic [DW-1:0] nops [3];
      nops[0] = 32'h00000000; nops[1] = 32'h03000000; nops[2] = 32'hFF000000;
      for (int i = 0; i < 7; i++) write_imem(3'(i), nops[i % 3]);
      write_imem(7, ADD_R0_R1_R2);
      kick({32'd4, 32'd3, 32'd2, 32'd1});
      wait_done(cyc, to);
      checks++; if (to || cyc != 18) begin errors++; $display("FAIL end_latency got %0d to=%b exp 18", cyc, to); end
      checks++; if (pc !== 4'd8) begin errors++; $display("FAIL end_pc got %0d exp 8", pc); end
      checks++; if (rget(0) !== 32'd5) begin errors++; $display("FAIL end_r0 got %h exp 5", rget(0)); end
      @(negedge CLK);
   endtask

`ifdef CTRL_BRANCH_EN
   task automatic test_branch();
      int cyc; bit to;
      write_imem(0, 32'h02000102);   // BEQ r0,r1,+2 -> pc 3
      write_imem(1, HALT);
      write_imem(2, HALT);
      write_imem(3, 32'h20000102);   // ADD r2 = r0 + r1
      write_imem(4, HALT);
      kick({32'h0, 32'h0, 32'd7, 32'd7});
      wait_done(cyc, to);
      checks++; if (to || cyc != 9) begin errors++; $display("FAIL beq_latency got %0d to=%b exp 9", cyc, to); end
      checks++; if (pc !== 4'd4 || rget(2) !== 32'd14) begin errors++;
         $display("FAIL beq_taken got pc=%0d r2=%h exp 4 e", pc, rget(2)); end
      @(negedge CLK);
      write_imem(0, 32'h02000180);   // BEQ offset -128 -> out of range
      kick({32'h0, 32'h0, 32'd7, 32'd7});
      wait_done(cyc, to);
      checks++; if (to || cyc != 3) begin errors++; $display("FAIL beq_oob_latency got %0d to=%b exp 3", cyc, to); end
      @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_add_halt();
      test_alu_ops();
      test_store_load();
      test_addr_err();
      test_reset_mid_run();
      test_busy_ignores();
      test_write_with_start();
      test_run_off_end();
`ifdef CTRL_BRANCH_EN
      test_branch();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
